// File: rtl/id_ex_register_if.sv
// ID/EX pipeline bundle: decode-side id_* signals in, execute-side ex_* signals out.
// master = decode stage / driver, slave = the ID/EX register.
interface id_ex_register_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  id_valid;
  logic [1:0]            id_wb_ctrl;
  logic [3:0]            id_m_ctrl;
  logic [6:0]            id_ex_ctrl;
  logic [DATA_WIDTH-1:0] id_pc_plus4;
  logic [DATA_WIDTH-1:0] id_read_data1;
  logic [DATA_WIDTH-1:0] id_read_data2;
  logic [DATA_WIDTH-1:0] id_imm;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;

  logic                  ex_valid;
  logic [1:0]            ex_wb_ctrl;
  logic [3:0]            ex_m_ctrl;
  logic [6:0]            ex_ex_ctrl;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;
  logic [DATA_WIDTH-1:0] ex_read_data1;
  logic [DATA_WIDTH-1:0] ex_read_data2;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [4:0]            ex_rs;
  logic [4:0]            ex_rt;
  logic [4:0]            ex_rd;
  logic                  ex_mem_read;

  modport master (
    output id_valid, id_wb_ctrl, id_m_ctrl, id_ex_ctrl, id_pc_plus4,
           id_read_data1, id_read_data2, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_wb_ctrl, ex_m_ctrl, ex_ex_ctrl, ex_pc_plus4,
           ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_mem_read
  );

  modport slave (
    input  id_valid, id_wb_ctrl, id_m_ctrl, id_ex_ctrl, id_pc_plus4,
           id_read_data1, id_read_data2, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_wb_ctrl, ex_m_ctrl, ex_ex_ctrl, ex_pc_plus4,
           ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_mem_read
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) control.
// Define ID_EX_PERF_EN to add the bubble_count port and its 32-bit counter.
module id_ex_register #(
  parameter int         DATA_WIDTH   = 32,
  parameter logic [4:0] BUBBLE_ALUOP = 5'b11111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  id_ex_register_if.slave      bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]          bubble_count
`endif
);

  localparam logic [6:0] BUBBLE_EX = {2'b00, BUBBLE_ALUOP};

  logic                  valid_q;
  logic [1:0]            wb_q;
  logic [3:0]            m_q;
  logic [6:0]            ex_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] rd1_q;
  logic [DATA_WIDTH-1:0] rd2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [4:0]            rs_q;
  logic [4:0]            rt_q;
  logic [4:0]            rd_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      wb_q    <= 2'b00;
      m_q     <= 4'b0000;
      ex_q    <= BUBBLE_EX;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else if (!stall) begin
      valid_q <= bus.id_valid;
      pc_q    <= bus.id_pc_plus4;
      rd1_q   <= bus.id_read_data1;
      rd2_q   <= bus.id_read_data2;
      imm_q   <= bus.id_imm;
      rs_q    <= bus.id_rs;
      rt_q    <= bus.id_rt;
      rd_q    <= bus.id_rd;
      // An invalid slot keeps its data but must not write, access memory or branch.
      if (bus.id_valid) begin
        wb_q <= bus.id_wb_ctrl;
        m_q  <= bus.id_m_ctrl;
        ex_q <= bus.id_ex_ctrl;
      end else begin
        wb_q <= 2'b00;
        m_q  <= 4'b0000;
        ex_q <= BUBBLE_EX;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (flush)
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign bubble_count = bubble_cnt;
`endif

  assign bus.ex_valid      = valid_q;
  assign bus.ex_wb_ctrl    = wb_q;
  assign bus.ex_m_ctrl     = m_q;
  assign bus.ex_ex_ctrl    = ex_q;
  assign bus.ex_pc_plus4   = pc_q;
  assign bus.ex_read_data1 = rd1_q;
  assign bus.ex_read_data2 = rd2_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_mem_read   = m_q[1];

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register between the decode-stage controller and the execute stage of the pipelined MIPS core. Each cycle it captures the controller's WB/M/EX control bundles together with the decode-stage operands and register specifiers. It supports stall (hold) and flush (bubble insertion) requests from the hazard and branch logic. It exports the registered load flag and `rt` so the hazard unit can detect load-use dependencies.

## Interface
- `DATA_WIDTH`, 32: width of PC and operand datapaths.
- `BUBBLE_ALUOP`, 5'b11111: ALUop code loaded on reset, flush or bubble; matches the controller's no-op default.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all registered contents.
- `flush`  in  1  load a bubble instead of decode-stage contents.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_wb_ctrl`  in  2  {RegWrite, MemToReg}.
- `id_m_ctrl`  in  4  {PCsrcForBNE, PCsrcForBEQ, MemRead, MemWrite}.
- `id_ex_ctrl`  in  7  {RegDst, ALUsrc, ALUop[4:0]}.
- `id_pc_plus4`, `id_read_data1`, `id_read_data2`, `id_imm`  in  DATA_WIDTH each  PC+4, register file operands, sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register specifiers.
- `ex_valid`, `ex_wb_ctrl`, `ex_m_ctrl`, `ex_ex_ctrl`, `ex_pc_plus4`, `ex_read_data1`, `ex_read_data2`, `ex_imm`, `ex_rs`, `ex_rt`, `ex_rd`  out  same widths as the `id_*` ports  registered copies.
- `ex_mem_read`  out  1  equals `ex_m_ctrl[1]`, for load-use detection.
- `bubble_count`  out  32  bubbles inserted since reset. Present only with `ID_EX_PERF_EN`.

## Operation
- The block holds one entry. Each rising edge applies the first matching rule, in priority order `rst` > `flush` > `stall` > load.
- Bubble value:
  - `ex_valid`=0, `ex_wb_ctrl`=2'b00, `ex_m_ctrl`=4'b0000.
  - `ex_ex_ctrl`={1'b0,1'b0,BUBBLE_ALUOP}.
  - All data and specifier outputs are 0.
- `rst`=1: load the bubble value. `bubble_count` is cleared to 0 and is not incremented.
- `flush`=1, no reset: load the bubble value regardless of `stall`. `bubble_count` increments by 1.
- `stall`=1, no flush: all outputs keep their previous values. `bubble_count` is unchanged.
- Otherwise (load):
  - All `ex_*` outputs take their `id_*` inputs.
  - If `id_valid`=0, the control bundles are forced to the bubble value while data fields are still captured. No write, memory access or branch can originate from an invalid slot.
- Control bit positions are fixed as listed; the execute, memory and writeback stages slice them by position.
- `ex_mem_read` is a combinational copy of the registered bit. It adds no extra latency.

## Timing
- Latency: 1 cycle from `id_*` to `ex_*`.
- There is no combinational path from any input to any output.
- Reset values: every output equals the bubble value. `ex_mem_read`=0 and `bubble_count`=0.
- Reset asserted mid-stall or mid-flush: the bubble value is loaded on that edge; the stall is ignored.
- `stall` and `flush` asserted together: flush wins and a bubble is loaded. Upstream must re-present the squashed instruction if it is still needed.
- Back-to-back flushes: each edge loads a bubble and increments `bubble_count`.
- `bubble_count` wraps from 32'hFFFFFFFF to 0.

## Configuration
- `ID_EX_PERF_EN` defined: the `bubble_count` port and its 32-bit counter are present, with the rules above.
- `ID_EX_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `id_*` driven to nonzero values. Required: `ex_ex_ctrl`=7'b0011111, all other outputs 0, `bubble_count`=0.
- Load: present R-type ADD with `id_wb_ctrl`=2'b10, `id_ex_ctrl`=7'b1000001, `id_read_data1`=32'h5, `id_rd`=5'd3, `id_valid`=1. Required: the same values on `ex_*` one cycle later and `ex_valid`=1.
- Stall: load a LW (`id_m_ctrl`=4'b0010, `id_rt`=5'd8), then assert `stall` for 3 cycles with changing inputs. Required: outputs frozen, `ex_mem_read`=1, `ex_rt`=8.
- Flush over stall: assert `stall`=1 and `flush`=1 together. Required: bubble loaded next cycle and `bubble_count` goes from 0 to 1.
- Invalid slot: `id_valid`=0 with `id_m_ctrl`=4'b0001 and `id_imm`=32'h10. Required: `ex_m_ctrl`=0, `ex_wb_ctrl`=0, `ex_imm`=32'h10.
- Wrap (perf build): force the counter to 32'hFFFFFFFF, then flush once. Required: `bubble_count`=0.
